// File: rtl/textmode_console_ctrl.sv
// textmode_console_ctrl
// Terminal-style write controller for an 80x60 text-mode character framebuffer.
// Takes bytes from the CPU side over a valid/ready handshake, prints printable
// characters at the cursor, interprets CR/LF/BS/FF, and runs a full-screen
// clear on FF. Every output is a register.
//
// Ports
//   CLK_SYS    system clock, posedge
//   RST        asynchronous reset, active-high
//   CMD_DATA   byte from the CPU interface
//   CMD_VALID  CMD_DATA is valid
//   CMD_READY  a byte is accepted on this cycle's edge when CMD_VALID is high
//   FB_WE      framebuffer write strobe, one cycle per cell
//   FB_ADDR    cell index row*COLS+col
//   FB_DATA    glyph code to write
//   CURSOR_X   current column
//   CURSOR_Y   current row
//   BUSY       high while a byte is being executed or the screen is clearing
module textmode_console_ctrl #(
  parameter int         COLS  = 80,
  parameter int         ROWS  = 60,
  parameter logic [6:0] BLANK = 7'h20
) (
  input  logic        CLK_SYS,
  input  logic        RST,
  input  logic [7:0]  CMD_DATA,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  output logic        FB_WE,
  output logic [12:0] FB_ADDR,
  output logic [6:0]  FB_DATA,
  output logic [6:0]  CURSOR_X,
  output logic [5:0]  CURSOR_Y,
  output logic        BUSY
);

  localparam logic [12:0] LAST_CELL = 13'(COLS * ROWS - 1);
  localparam logic [6:0]  X_MAX     = 7'(COLS - 1);
  localparam logic [5:0]  Y_MAX     = 6'(ROWS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    CLEAR = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        ready_q, ready_d;
  logic        we_q, we_d;
  logic [12:0] addr_q, addr_d;
  logic [6:0]  data_q, data_d;
  logic [6:0]  x_q, x_d;
  logic [5:0]  y_q, y_d;
  logic        busy_q, busy_d;
  logic [12:0] cnt_q, cnt_d;
  logic [7:0]  byte_q, byte_d;

  // Row advance with wrap to the top; there is no scrolling.
  function automatic logic [5:0] next_row(input logic [5:0] y);
    return (y == Y_MAX) ? 6'd0 : y + 6'd1;
  endfunction

  function automatic logic [12:0] cell_index(input logic [6:0] x, input logic [5:0] y);
    return 13'(y) * 13'(COLS) + 13'(x);
  endfunction

  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    byte_d  = byte_q;

    case (state_q)
      IDLE: begin
        // Also the path that raises READY after reset and after a clear.
        ready_d = 1'b1;
        if (CMD_VALID && ready_q) begin
          byte_d  = CMD_DATA;
          ready_d = 1'b0;
          state_d = EXEC;
        end
      end

      EXEC: begin
        state_d = IDLE;
        ready_d = 1'b1;
        if (byte_q >= 8'h20 && byte_q <= 8'h7E) begin
          we_d   = 1'b1;
          addr_d = cell_index(x_q, y_q);
          data_d = byte_q[6:0];
          if (x_q == X_MAX) begin
            x_d = 7'd0;
            y_d = next_row(y_q);
          end else begin
            x_d = x_q + 7'd1;
          end
        end else begin
          case (byte_q)
            8'h0D: x_d = 7'd0;
            8'h0A: y_d = next_row(y_q);
            8'h08: if (x_q != 7'd0) x_d = x_q - 7'd1;
            8'h0C: begin
              x_d     = 7'd0;
              y_d     = 6'd0;
              cnt_d   = 13'd0;
              ready_d = 1'b0;
              state_d = CLEAR;
            end
            default: ;
          endcase
        end
      end

      CLEAR: begin
        // READY stays low here; IDLE raises it the cycle after the last strobe.
        we_d   = 1'b1;
        addr_d = cnt_q;
        data_d = BLANK;
        cnt_d  = cnt_q + 13'd1;
        if (cnt_q == LAST_CELL) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK_SYS or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 13'd0;
      data_q  <= 7'd0;
      x_q     <= 7'd0;
      y_q     <= 6'd0;
      busy_q  <= 1'b0;
      cnt_q   <= 13'd0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      x_q     <= x_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  // The latched command byte is only read in EXEC, after a load.
  always_ff @(posedge CLK_SYS) begin
    byte_q <= byte_d;
  end

  assign CMD_READY = ready_q;
  assign FB_WE     = we_q;
  assign FB_ADDR   = addr_q;
  assign FB_DATA   = data_q;
  assign CURSOR_X  = x_q;
  assign CURSOR_Y  = y_q;
  assign BUSY      = busy_q;

endmodule

// File: tb/tb_textmode_console_ctrl.sv
module tb_textmode_console_ctrl;

  logic        CLK_SYS = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  CMD_DATA = 8'h00;
  logic        CMD_VALID = 1'b0;
  logic        CMD_READY;
  logic        FB_WE;
  logic [12:0] FB_ADDR;
  logic [6:0]  FB_DATA;
  logic [6:0]  CURSOR_X;
  logic [5:0]  CURSOR_Y;
  logic        BUSY;

  textmode_console_ctrl dut (
    .CLK_SYS  (CLK_SYS),
    .RST      (RST),
    .CMD_DATA (CMD_DATA),
    .CMD_VALID(CMD_VALID),
    .CMD_READY(CMD_READY),
    .FB_WE    (FB_WE),
    .FB_ADDR  (FB_ADDR),
    .FB_DATA  (FB_DATA),
    .CURSOR_X (CURSOR_X),
    .CURSOR_Y (CURSOR_Y),
    .BUSY     (BUSY)
  );

  always #5 CLK_SYS = ~CLK_SYS;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge CLK_SYS) cyc <= cyc + 1;

  // Reference model: cursor position plus the list of framebuffer writes
  // still owed, each tagged with the cycle it must appear on.
  typedef struct {
    int addr;
    int data;
    int cyc;
    int rdy;
  } wr_t;
  wr_t wq[$];
  int  mx = 0;
  int  my = 0;
  bit  chk_en = 1'b0;
  int  we_count = 0;
  int  last_addr = -1;
  int  last_data = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Called just after the accept edge; cyc already holds that edge's count.
  task automatic model_apply(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      wq.push_back('{addr: my * 80 + mx, data: int'(b[6:0]), cyc: cyc + 1, rdy: 1});
      mx = mx + 1;
      if (mx == 80) begin
        mx = 0;
        my = (my + 1) % 60;
      end
    end else if (b == 8'h0D) begin
      mx = 0;
    end else if (b == 8'h0A) begin
      my = (my + 1) % 60;
    end else if (b == 8'h08) begin
      if (mx > 0) mx = mx - 1;
    end else if (b == 8'h0C) begin
      for (int k = 0; k < 4800; k++)
        wq.push_back('{addr: k, data: 32, cyc: cyc + 2 + k, rdy: 0});
      mx = 0;
      my = 0;
    end
  endtask

  // Compare process: every write against the owed list, and the idle
  // cursor/busy state whenever the controller is ready for a byte.
  always @(negedge CLK_SYS) begin
    if (chk_en && !RST) begin
      if (FB_WE === 1'b1) begin
        we_count++;
        last_addr = int'(FB_ADDR);
        last_data = int'(FB_DATA);
        if (wq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_we addr=%0d data=%0d cycle=%0d", FB_ADDR, FB_DATA, cyc);
        end else begin
          wr_t e;
          e = wq.pop_front();
          check("wr_addr", FB_ADDR, e.addr);
          check("wr_data", FB_DATA, e.data);
          check("wr_cycle", cyc, e.cyc);
          check("wr_ready", CMD_READY, e.rdy);
        end
      end else if (FB_WE !== 1'b0) begin
        total++;
        bad++;
        $display("FAIL we_unknown actual=%b required=0/1", FB_WE);
      end
      if (CMD_READY === 1'b1) begin
        check("idle_x", CURSOR_X, mx);
        check("idle_y", CURSOR_Y, my);
        check("idle_busy", BUSY, 0);
        check("idle_drained", wq.size(), 0);
      end
    end
  end

  // Starts and ends just after a falling edge.
  task automatic send_byte(input logic [7:0] b);
    int w;
    repeat ($urandom_range(0, 2)) @(negedge CLK_SYS);
    CMD_DATA  = b;
    CMD_VALID = 1'b1;
    w = 0;
    while (CMD_READY !== 1'b1 && w < 6000) begin
      @(negedge CLK_SYS);
      w++;
    end
    if (w >= 6000) begin
      total++;
      bad++;
      $display("FAIL accept_timeout byte=%0h actual=not_ready required=ready", b);
      CMD_VALID = 1'b0;
      #1;
      return;
    end
    @(posedge CLK_SYS);
    #1;
    model_apply(b);
    CMD_VALID = 1'b0;
    CMD_DATA  = 8'($urandom);
    @(negedge CLK_SYS);
    check("acc_ready_low", CMD_READY, 0);
    check("acc_busy", BUSY, 1);
    @(negedge CLK_SYS);
    if (b != 8'h0C) check("ready_back", CMD_READY, 1);
    #1;
  endtask

  task automatic send_printable(input int n);
    for (int i = 0; i < n; i++) send_byte(8'($urandom_range(32, 126)));
  endtask

  int we0;

  initial begin
    // Reset state
    repeat (3) @(negedge CLK_SYS);
    check("rst_ready", CMD_READY, 0);
    check("rst_we", FB_WE, 0);
    check("rst_addr", FB_ADDR, 0);
    check("rst_data", FB_DATA, 0);
    check("rst_x", CURSOR_X, 0);
    check("rst_y", CURSOR_Y, 0);
    check("rst_busy", BUSY, 0);
    RST = 1'b0;
    #1;
    check("rel_ready_low", CMD_READY, 0);
    @(posedge CLK_SYS);
    #1;
    check("rel_ready_high", CMD_READY, 1);
    chk_en = 1'b1;
    @(negedge CLK_SYS);
    #1;

    // 'A' at the origin
    we0 = we_count;
    send_byte(8'h41);
    check("t1_we_count", we_count - we0, 1);
    check("t1_addr", last_addr, 0);
    check("t1_data", last_data, 8'h41);
    check("t1_x", CURSOR_X, 1);

    // Line wrap from (79,5)
    send_byte(8'h0D);
    repeat (5) send_byte(8'h0A);
    send_printable(79);
    check("t2_pre_x", CURSOR_X, 79);
    check("t2_pre_y", CURSOR_Y, 5);
    send_byte(8'h42);
    check("t2_addr", last_addr, 479);
    check("t2_data", last_data, 8'h42);
    check("t2_x", CURSOR_X, 0);
    check("t2_y", CURSOR_Y, 6);

    // Bottom-right wrap to the origin
    repeat (53) send_byte(8'h0A);
    send_printable(79);
    check("t3_pre_y", CURSOR_Y, 59);
    send_byte(8'h43);
    check("t3_addr", last_addr, 4799);
    check("t3_x", CURSOR_X, 0);
    check("t3_y", CURSOR_Y, 0);

    // Control codes from (10,3)
    repeat (3) send_byte(8'h0A);
    send_printable(10);
    we0 = we_count;
    send_byte(8'h0D);
    check("t4_cr_x", CURSOR_X, 0);
    check("t4_cr_y", CURSOR_Y, 3);
    send_byte(8'h0A);
    check("t4_lf_y", CURSOR_Y, 4);
    send_byte(8'h08);
    check("t4_bs0_x", CURSOR_X, 0);
    check("t4_ctrl_no_we", we_count - we0, 0);
    send_byte(8'h31);
    send_byte(8'h08);
    check("t4_bs_x", CURSOR_X, 0);
    check("t4_bs_y", CURSOR_Y, 4);

    // Randomized byte stream (no form feed)
    for (int i = 0; i < 300; i++) begin
      int r;
      logic [7:0] b;
      r = $urandom_range(0, 99);
      if (r < 70)      b = 8'($urandom_range(32, 126));
      else if (r < 78) b = 8'h0D;
      else if (r < 86) b = 8'h0A;
      else if (r < 94) b = 8'h08;
      else if (r < 97) b = 8'($urandom_range(127, 255));
      else             b = 8'($urandom_range(0, 7));
      send_byte(b);
    end

    // Full clear with a byte held waiting behind it
    we0 = we_count;
    send_byte(8'h0C);
    send_byte(8'h5A);
    check("t5_we_count", we_count - we0, 4801);
    check("t5_z_addr", last_addr, 0);
    check("t5_z_data", last_data, 8'h5A);
    check("t5_x", CURSOR_X, 1);
    check("t5_y", CURSOR_Y, 0);

    // Reset in the middle of a clear
    send_byte(8'h0C);
    repeat (100) @(negedge CLK_SYS);
    chk_en = 1'b0;
    RST = 1'b1;
    #1;
    check("t6_we", FB_WE, 0);
    check("t6_x", CURSOR_X, 0);
    check("t6_y", CURSOR_Y, 0);
    check("t6_busy", BUSY, 0);
    check("t6_ready", CMD_READY, 0);
    wq.delete();
    mx = 0;
    my = 0;
    repeat (2) @(negedge CLK_SYS);
    RST = 1'b0;
    @(posedge CLK_SYS);
    #1;
    check("t6_ready_after", CMD_READY, 1);
    check("t6_we_after", FB_WE, 0);
    chk_en = 1'b1;
    we0 = we_count;
    send_byte(8'h00);
    send_byte(8'h9B);
    check("t6_ignored_no_we", we_count - we0, 0);
    check("t6_ign_x", CURSOR_X, 0);
    send_byte(8'h51);
    check("t6_q_addr", last_addr, 0);
    check("t6_q_data", last_data, 8'h51);

    begin
      int w;
      w = 0;
      while (wq.size() != 0 && w < 100) begin
        @(negedge CLK_SYS);
        w++;
      end
    end
    check("final_drain", wq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
